// File: rtl/vga_stream_out.sv
// VGA raster generator fed by a valid/ready RGB pixel stream with start-of-frame alignment.
// Define VGA_STREAM_OUT_STATS_EN to add the frame_count / underflow_count statistics ports.
module vga_stream_out #(
  parameter int   COLOR_WIDTH = 4,
  parameter int   H_VISIBLE   = 640,
  parameter int   H_FRONT     = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BACK      = 48,
  parameter int   V_VISIBLE   = 480,
  parameter int   V_FRONT     = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BACK      = 33,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic                   s_sof,
  input  logic [COLOR_WIDTH-1:0] s_red,
  input  logic [COLOR_WIDTH-1:0] s_grn,
  input  logic [COLOR_WIDTH-1:0] s_blu,
  output logic [COLOR_WIDTH-1:0] vga_red,
  output logic [COLOR_WIDTH-1:0] vga_grn,
  output logic [COLOR_WIDTH-1:0] vga_blu,
  output logic                   vga_hsync,
  output logic                   vga_vsync,
  output logic                   locked,
  output logic                   underflow
`ifdef VGA_STREAM_OUT_STATS_EN
  ,
  output logic [15:0]            frame_count,
  output logic [15:0]            underflow_count
`endif
);

  // Handshake: a pixel transfers on a rising clk edge where s_valid && s_ready;
  // s_valid and the pixel fields must stay stable until that edge.

  localparam int H_WHOLE = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_WHOLE = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_WHOLE);
  localparam int VW      = $clog2(V_WHOLE);

  localparam logic [HW-1:0] H_LAST  = HW'(H_WHOLE - 1);
  localparam logic [HW-1:0] H_VIS   = HW'(H_VISIBLE);
  localparam logic [HW-1:0] H_SS    = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] H_SE    = HW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST  = VW'(V_WHOLE - 1);
  localparam logic [VW-1:0] V_VIS   = VW'(V_VISIBLE);
  localparam logic [VW-1:0] V_SS    = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] V_SE    = VW'(V_VISIBLE + V_FRONT + V_SYNC);

  localparam logic [0:0] SYNC_WAIT = 1'b0;
  localparam logic [0:0] RUN       = 1'b1;

  logic [HW-1:0]          h_q, h_d;
  logic [VW-1:0]          v_q, v_d;
  logic [0:0]             state_q, state_d;
  logic [COLOR_WIDTH-1:0] red_q, red_d, grn_q, grn_d, blu_q, blu_d;
  logic                   hsync_q, hsync_d, vsync_q, vsync_d;
  logic                   underflow_q, underflow_d;
  logic                   h_wrap, v_wrap, visible, at_origin, show;

  always_comb begin
    h_wrap    = (h_q == H_LAST);
    v_wrap    = (v_q == V_LAST);
    h_d       = h_wrap ? '0 : h_q + 1'b1;
    v_d       = v_q;
    if (h_wrap) begin
      v_d = v_wrap ? '0 : v_q + 1'b1;
    end
    visible   = (h_q < H_VIS) && (v_q < V_VIS);
    at_origin = (h_q == '0) && (v_q == '0);
    hsync_d   = ((h_q >= H_SS) && (h_q < H_SE)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_d   = ((v_q >= V_SS) && (v_q < V_SE)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  end

  // A held SOF pixel is only released at the raster origin; anything else
  // seen while waiting is flushed so the head of the stream lands on a frame start.
  always_comb begin
    state_d     = state_q;
    s_ready     = 1'b0;
    show        = 1'b0;
    underflow_d = 1'b0;
    case (state_q)
      SYNC_WAIT: begin
        if (s_valid) begin
          if (!s_sof) begin
            s_ready = 1'b1;
          end else if (at_origin) begin
            s_ready = 1'b1;
            show    = 1'b1;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (visible) begin
          if (!s_valid || (s_sof != at_origin)) begin
            underflow_d = 1'b1;
            state_d     = SYNC_WAIT;
          end else begin
            s_ready = 1'b1;
            show    = 1'b1;
          end
        end
      end
      default: state_d = SYNC_WAIT;
    endcase
    red_d = show ? s_red : '0;
    grn_d = show ? s_grn : '0;
    blu_d = show ? s_blu : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q         <= '0;
      v_q         <= '0;
      state_q     <= SYNC_WAIT;
      red_q       <= '0;
      grn_q       <= '0;
      blu_q       <= '0;
      hsync_q     <= ~SYNC_ACTIVE;
      vsync_q     <= ~SYNC_ACTIVE;
      underflow_q <= 1'b0;
    end else begin
      h_q         <= h_d;
      v_q         <= v_d;
      state_q     <= state_d;
      red_q       <= red_d;
      grn_q       <= grn_d;
      blu_q       <= blu_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      underflow_q <= underflow_d;
    end
  end

  assign vga_red   = red_q;
  assign vga_grn   = grn_q;
  assign vga_blu   = blu_q;
  assign vga_hsync = hsync_q;
  assign vga_vsync = vsync_q;
  assign locked    = (state_q == RUN);
  assign underflow = underflow_q;

`ifdef VGA_STREAM_OUT_STATS_EN
  logic [15:0] frame_cnt_q, uf_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
      uf_cnt_q    <= '0;
    end else begin
      if ((state_q == RUN) && h_wrap && v_wrap) begin
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
      if (underflow_d && (uf_cnt_q != 16'hFFFF)) begin
        uf_cnt_q <= uf_cnt_q + 1'b1;
      end
    end
  end

  assign frame_count     = frame_cnt_q;
  assign underflow_count = uf_cnt_q;
`endif

endmodule

// File: tb/tb_vga_stream_out.sv
// Bench for vga_stream_out on a 14x7 raster: driver pushes expected pixels, monitor pops and compares.
module tb_vga_stream_out;

  localparam int HT = 14;
  localparam int VT = 7;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid, s_ready, s_sof;
  logic [3:0] s_red, s_grn, s_blu;
  logic [3:0] vga_red, vga_grn, vga_blu;
  logic       vga_hsync, vga_vsync, locked, underflow;
`ifdef VGA_STREAM_OUT_STATS_EN
  logic [15:0] frame_count, underflow_count;
`endif

  int checks   = 0;
  int failures = 0;
  int n_push   = 0;
  int n_pop    = 0;
  int uf_seen  = 0;
  int hs_low   = 0;
  int vs_low   = 0;
  bit chk_misalign = 1'b0;
  logic [11:0] exp_q[$];
  logic [11:0] pins_s, exp_s;

  always #5 clk = ~clk;

  vga_stream_out #(
    .COLOR_WIDTH(4), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .SYNC_ACTIVE(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof),
    .s_red(s_red), .s_grn(s_grn), .s_blu(s_blu),
    .vga_red(vga_red), .vga_grn(vga_grn), .vga_blu(vga_blu),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .locked(locked), .underflow(underflow)
`ifdef VGA_STREAM_OUT_STATS_EN
    , .frame_count(frame_count), .underflow_count(underflow_count)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference raster position: (mh,mv) is the current count, (ph,pv) the one the pins reflect.
  int mh = 0, mv = 0, ph = 0, pv = 0;
  bit pvalid = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      mh     <= 0;
      mv     <= 0;
      pvalid <= 1'b0;
    end else begin
      ph     <= mh;
      pv     <= mv;
      pvalid <= 1'b1;
      if (mh == HT - 1) begin
        mh <= 0;
        mv <= (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh <= mh + 1;
      end
    end
  end

  // Monitor
  always @(negedge clk) begin
    pins_s = {vga_red, vga_grn, vga_blu};
    if (vga_hsync === 1'b0) hs_low++;
    if (vga_vsync === 1'b0) vs_low++;
    if (underflow === 1'b1) uf_seen++;
    if (!pvalid) begin
      check("reset_colour", 32'(pins_s), 32'h0);
      check("reset_hsync", 32'(vga_hsync), 32'h1);
      check("reset_vsync", 32'(vga_vsync), 32'h1);
      check("reset_locked", 32'(locked), 32'h0);
      check("reset_underflow", 32'(underflow), 32'h0);
    end else begin
      check("hsync", 32'(vga_hsync), (ph >= 10 && ph < 12) ? 32'h0 : 32'h1);
      check("vsync", 32'(vga_vsync), (pv == 5) ? 32'h0 : 32'h1);
      if (!(ph < 8 && pv < 4)) begin
        check("blank_black", 32'(pins_s), 32'h0);
      end else if (pins_s != 12'h0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pixel", 32'(pins_s), 32'h0);
        end else begin
          exp_s = exp_q.pop_front();
          n_pop++;
          check("pixel", 32'(pins_s), 32'(exp_s));
        end
      end
    end
  end

  function automatic logic [11:0] pix(input int f, input int i);
    logic [3:0] r;
    logic [7:0] ii;
    r  = 4'(f + 1);
    ii = 8'(i);
    return {r, ii};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    s_sof   = 1'b0;
    repeat (n) next_cycle();
  endtask

  task automatic drive_pixel(input logic sof, input logic [11:0] p, input bit shown);
    int n;
    bit acc;
    n   = 0;
    acc = 1'b0;
    if (shown) begin
      exp_q.push_back(p);
      n_push++;
    end
    s_valid = 1'b1;
    s_sof   = sof;
    {s_red, s_grn, s_blu} = p;
    while (!acc) begin
      @(negedge clk);
      if (chk_misalign && mh == 0 && mv == 2) begin
        check("sof_misalign_ready", 32'(s_ready), 32'h0);
        chk_misalign = 1'b0;
      end
      acc = s_ready;
      next_cycle();
      n++;
      if (!acc && n >= 300) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout pixel=%0h waited=%0d required=accept", p, n);
        acc = 1'b1;
      end
    end
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  task automatic send_frame(input int f, input int first, input int last);
    for (int i = first; i < last; i++) drive_pixel(i == 0, pix(f, i), 1'b1);
  endtask

  task automatic wait_pos(input int h, input int v);
    int n;
    n = 0;
    while (!(mh == h && mv == v) && n < 200) begin
      next_cycle();
      n++;
    end
  endtask

  initial begin
    int h0, v0;
    rst = 1'b1;
    s_valid = 1'b0;
    s_sof = 1'b0;
    {s_red, s_grn, s_blu} = 12'h0;
    repeat (3) next_cycle();
    rst = 1'b0;

    // Idle raster: sync duty over two whole frames
    idle(2);
    h0 = hs_low;
    v0 = vs_low;
    idle(196);
    check("hsync_low_cycles", 32'(hs_low - h0), 32'd28);
    check("vsync_low_cycles", 32'(vs_low - v0), 32'd28);
    check("idle_locked", 32'(locked), 32'h0);

    // SOF offered mid-line, held until the origin, then three clean frames
    wait_pos(5, 0);
    send_frame(0, 0, 1);
    check("sof_accept_pos", 32'(mv * 16 + mh), 32'd1);
    check("locked_after_sof", 32'(locked), 32'h1);
    send_frame(0, 1, 32);
    send_frame(1, 0, 32);
    send_frame(2, 0, 32);
    check("no_underflow_3frames", 32'(uf_seen), 32'd0);

    // Valid gap at y=1,x=3; rest of that frame is flushed
    send_frame(3, 0, 11);
    idle(1);
    for (int i = 11; i < 32; i++) drive_pixel(1'b0, pix(3, i), 1'b0);
    check("gap_underflow", 32'(uf_seen), 32'd1);
    check("gap_unlocked", 32'(locked), 32'h0);

    // Three stray pixels before SOF are dropped
    for (int k = 0; k < 3; k++) drive_pixel(1'b0, pix(14, k), 1'b0);
    send_frame(4, 0, 1);
    check("relock", 32'(locked), 32'h1);
    send_frame(4, 1, 32);

    // Early SOF at y=2,x=0
    send_frame(5, 0, 16);
    chk_misalign = 1'b1;
    send_frame(6, 0, 1);
    check("misalign_underflow", 32'(uf_seen), 32'd2);
    send_frame(6, 1, 32);

    // Reset at h=5,v=2 mid-frame
    send_frame(7, 0, 21);
    check("rst_point", 32'(mv * 16 + mh), 32'd37);
    rst = 1'b1;
    s_valid = 1'b0;
    next_cycle();
    rst = 1'b0;
    check("post_rst_locked", 32'(locked), 32'h0);
    check("post_rst_underflow", 32'(underflow), 32'h0);
    idle(20);
    check("rst_no_underflow", 32'(uf_seen), 32'd2);
    send_frame(8, 0, 32);
    idle(30);

    check("all_displayed", 32'(n_pop), 32'(n_push));
    check("expected_total", 32'(n_push), 32'd240);
`ifdef VGA_STREAM_OUT_STATS_EN
    check("underflow_count", 32'(underflow_count), 32'(uf_seen));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vga_stream_out.md
Name: vga_stream_out

Overview:
- Downstream consumer of the pixel-pattern/frame-source stages.
- Accepts a valid/ready RGB pixel stream with a start-of-frame marker and runs the VGA horizontal/vertical timing counters.
- Aligns incoming frames to the raster, drives registered colour and sync pins, and reports underflow.
- Single clock domain: clk is the pixel clock.

Parameters:
- COLOR_WIDTH, 4, bits per colour channel
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE, 0, asserted level of hsync/vsync (0 = active low)

Ports:
- clk  input  1  pixel clock
- rst  input  1  synchronous active-high reset
- s_valid  input  1  stream pixel valid
- s_ready  output  1  stream pixel accepted this cycle when high with s_valid
- s_sof  input  1  pixel is first of frame (x=0, y=0)
- s_red  input  COLOR_WIDTH  pixel red
- s_grn  input  COLOR_WIDTH  pixel green
- s_blu  input  COLOR_WIDTH  pixel blue
- vga_red  output  COLOR_WIDTH  registered red to pins
- vga_grn  output  COLOR_WIDTH  registered green to pins
- vga_blu  output  COLOR_WIDTH  registered blue to pins
- vga_hsync  output  1  registered horizontal sync
- vga_vsync  output  1  registered vertical sync
- locked  output  1  high while in RUN state
- underflow  output  1  one-cycle pulse on underflow or misalignment

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- H_WHOLE = H_VISIBLE+H_FRONT+H_SYNC+H_BACK; V_WHOLE is formed the same way. Counter widths are $clog2 of each whole value.
- h_count runs 0..H_WHOLE-1 and wraps to 0. v_count increments when h_count wraps, runs 0..V_WHOLE-1, and wraps to 0.
- visible = (h_count < H_VISIBLE) && (v_count < V_VISIBLE).
- hsync is asserted for h_count in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC). vsync uses the same rule on v_count.
- All pin outputs are registered: each reflects the counter position one cycle earlier. Colour and syncs share that single pipeline stage, so they stay mutually aligned.
- Colours are 0 whenever the position is not visible, or whenever the state is not RUN.
- Reset values:
  - h_count = v_count = 0
  - state = SYNC_WAIT
  - vga colours = 0
  - hsync and vsync = !SYNC_ACTIVE
  - locked = 0, underflow = 0
- State SYNC_WAIT:
  - s_valid && !s_sof: s_ready=1, and the pixel is dropped (flush to the frame boundary).
  - s_valid && s_sof: s_ready=0, and the pixel is held at the head.
  - At h_count==0 && v_count==0 with s_valid && s_sof: consume the pixel (s_ready=1), display it, and move to RUN in the same cycle.
- State RUN:
  - s_ready = visible && s_valid; no pixels are consumed during blanking.
  - visible && !s_valid: output black, pulse underflow, go to SYNC_WAIT.
  - visible && s_valid && s_sof at any position other than (0,0): do not consume, pulse underflow, go to SYNC_WAIT. The held SOF pixel then aligns at the next frame start.
  - visible && s_valid && !s_sof at (0,0): treated as a misalignment, handled the same way as above.
- Counters and syncs free-run in every state. Leaving RUN never disturbs raster timing.
- A reset mid-frame returns all outputs to reset values on the next edge and restarts the raster at (0,0).

Optional Feature:
- Macro: VGA_STREAM_OUT_STATS_EN.
- When defined, two output ports are added:
  - frame_count[15:0]: increments when v_count wraps while in RUN.
  - underflow_count[15:0]: increments on each underflow pulse and saturates at 0xFFFF.
  - Both reset to 0.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Use small timing for speed: H 8/2/2/2 and V 4/1/1/1 (H_WHOLE=14, V_WHOLE=7).
- Reset, then s_valid=0 for 200 cycles -> hsync low for exactly 2 of every 14 cycles (h 10..11, one cycle late); vsync low for 14 cycles per 98; colours 0; locked=0.
- Feed a continuous frame source starting with s_sof at cycle 5 -> pixel held until raster (0,0); locked=1; pin pixel k of line y equals source pixel y*8+k; 32 pixels consumed per frame; no underflow over 3 frames.
- Feed 3 non-SOF pixels before SOF -> all 3 dropped while in SYNC_WAIT; the SOF pixel appears first at pins.
- In RUN, drop s_valid at y=1, x=3 -> underflow pulses once; pin colour 0; locked=0; resync at the next frame's (0,0).
- Assert s_sof at y=2, x=0 while in RUN -> underflow pulse; s_ready=0 for that pixel; it is displayed at the next (0,0).
- Assert rst at h=5, v=2 -> the next cycle shows reset values; counters restart at 0; sync timing resumes from line 0.
